// File: rtl/sap_bcd_converter_if.sv
// Handshake/result bundle between the SAP output register and the BCD converter.
// The master drives start/bin_in. The slave, which is the converter, returns the BCD result and status.
interface sap_bcd_converter_if #(
  parameter int IN_WIDTH = 8,
  parameter int DIGITS   = 4
);
  logic                  start;
  logic [IN_WIDTH-1:0]   bin_in;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  busy;
  logic                  done;
  logic                  neg;

  modport master (output start, bin_in, input  bcd_out, busy, done, neg);
  modport slave  (input  start, bin_in, output bcd_out, busy, done, neg);
endinterface

// File: rtl/sap_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per cycle.
// Optional macro SAP_BCD_SIGNED_EN: treat bin_in as two's complement, report sign on neg.
module sap_bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module sap_bcd_converter #(
  parameter int IN_WIDTH = 8,
  parameter int DIGITS   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  sap_bcd_converter_if.slave    bus
);
  localparam int CW = $clog2(IN_WIDTH + 1);
  localparam int SW = 4 * DIGITS + IN_WIDTH;

  function automatic longint pow10(input int n);
    longint r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam longint MAX_IN  = (longint'(1) << IN_WIDTH) - 1;
  localparam longint DEC_CAP = pow10(DIGITS);

  generate
    if (DEC_CAP <= MAX_IN) begin : g_digits_too_few
      $error("sap_bcd_converter: DIGITS too small for IN_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nxt;

  logic [DIGITS-1:0][3:0] scratch, scratch_adj;
  logic [IN_WIDTH-1:0]    shift_reg;
  logic [CW-1:0]          cnt;
  logic [SW-1:0]          shifted;
  logic [4*DIGITS-1:0]    bcd_q;
  logic                   done_q, neg_q, neg_pend;
  logic                   load, shift_en, commit;
  logic [IN_WIDTH-1:0]    load_val;
  logic                   sign_in;

  // Per-digit add-3 correction on the registered scratch value
  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      sap_bcd_digit_adj u_adj (.d(scratch[g]), .q(scratch_adj[g]));
    end
  endgenerate

  assign shifted = {scratch_adj, shift_reg} << 1;

`ifdef SAP_BCD_SIGNED_EN
  // Negation of the most negative value wraps to itself, which reads back as its full magnitude unsigned
  assign sign_in  = bus.bin_in[IN_WIDTH-1];
  assign load_val = sign_in ? (~bus.bin_in + 1'b1) : bus.bin_in;
`else
  assign sign_in  = 1'b0;
  assign load_val = bus.bin_in;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift_en  = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE:  if (bus.start) begin
               load      = 1'b1;
               state_nxt = SHIFT;
             end
      SHIFT: begin
               shift_en = 1'b1;
               if (cnt == CW'(1)) state_nxt = DONE;
             end
      DONE:  begin
               commit    = 1'b1;
               state_nxt = IDLE;
             end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scratch   <= '0;
      shift_reg <= '0;
      cnt       <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
      neg_q     <= 1'b0;
      neg_pend  <= 1'b0;
    end else begin
      done_q <= commit;
      if (load) begin
        scratch   <= '0;
        shift_reg <= load_val;
        cnt       <= CW'(IN_WIDTH);
        neg_pend  <= sign_in;
      end
      if (shift_en) begin
        scratch   <= shifted[SW-1:IN_WIDTH];
        shift_reg <= shifted[IN_WIDTH-1:0];
        cnt       <= cnt - 1'b1;
      end
      if (commit) begin
        bcd_q <= scratch;
        neg_q <= neg_pend;
      end
    end
  end

  assign bus.bcd_out = bcd_q;
  assign bus.done    = done_q;
  assign bus.neg     = neg_q;
  assign bus.busy    = (state != IDLE);
endmodule

// File: tb/tb_sap_bcd_converter.sv
// Self-checking bench for sap_bcd_converter: directed and random conversions against a decimal model.
module tb_sap_bcd_converter;
  localparam int IN_WIDTH = 8;
  localparam int DIGITS   = 4;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  sap_bcd_converter_if #(.IN_WIDTH(IN_WIDTH), .DIGITS(DIGITS)) bus ();
  sap_bcd_converter #(.IN_WIDTH(IN_WIDTH), .DIGITS(DIGITS)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decimal digits of the value's magnitude, by repeated division
  function automatic logic [15:0] model_bcd(input logic [7:0] v);
    int m;
    logic [15:0] r;
`ifdef SAP_BCD_SIGNED_EN
    m = int'($signed(v));
    if (m < 0) m = -m;
`else
    m = int'(v);
`endif
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic model_neg(input logic [7:0] v);
`ifdef SAP_BCD_SIGNED_EN
    return v[7];
`else
    return 1'b0;
`endif
  endfunction

  // Starts one conversion and observes the following 14 cycles
  task automatic run_conv(input logic [7:0] v, output int lat, output int busy_cnt,
                          output int done_cnt, output logic [15:0] res, output logic rneg);
    bus.start = 1'b1; bus.bin_in = v;
    tick();
    bus.start = 1'b0; bus.bin_in = 8'($urandom);
    lat = -1; done_cnt = 0; res = 'x; rneg = 1'bx;
    busy_cnt = bus.busy ? 1 : 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (lat < 0) begin lat = k; res = bus.bcd_out; rneg = bus.neg; end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b0; bus.bin_in = '0;
    tick(); tick();
    vectors++;
    if ({bus.bcd_out, bus.busy, bus.done, bus.neg} !== 19'h0) begin
      miscompares++;
      $display("FAIL reset: got bcd=%h busy=%b done=%b neg=%b expected all 0",
               bus.bcd_out, bus.busy, bus.done, bus.neg);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_zero();
    int lat, bc, dc; logic [15:0] res; logic n;
    run_conv(8'd0, lat, bc, dc, res, n);
    vectors++;
    if (lat !== 9) begin miscompares++; $display("FAIL zero_latency: got %0d expected 9", lat); end
    vectors++;
    if (bc !== 9) begin miscompares++; $display("FAIL zero_busy_cycles: got %0d expected 9", bc); end
    vectors++;
    if (res !== 16'h0000) begin miscompares++; $display("FAIL zero_bcd: got %h expected 0000", res); end
  endtask

  task automatic test_values();
    logic [7:0] vals[$];
    int lat, bc, dc; logic [15:0] res; logic n;
    vals = '{8'd255, 8'd99, 8'd100, 8'hFF, 8'h80, 8'h7F, 8'd1, 8'd9, 8'd10};
    for (int i = 0; i < 20; i++) vals.push_back(8'($urandom_range(0, 255)));
    foreach (vals[i]) begin
      run_conv(vals[i], lat, bc, dc, res, n);
      vectors++;
      if (res !== model_bcd(vals[i]) || n !== model_neg(vals[i])) begin
        miscompares++;
        $display("FAIL conv_%h: got bcd=%h neg=%b expected bcd=%h neg=%b",
                 vals[i], res, n, model_bcd(vals[i]), model_neg(vals[i]));
      end
      vectors++;
      if (dc !== 1 || lat !== 9) begin
        miscompares++;
        $display("FAIL done_pulse_%h: got count=%0d latency=%0d expected 1 and 9", vals[i], dc, lat);
      end
    end
  endtask

  task automatic test_ignore_start();
    int dc; logic [15:0] res;
    int lat, bc, dc2; logic [15:0] res2; logic n;
    bus.start = 1'b1; bus.bin_in = 8'd42;
    tick();
    bus.start = 1'b0;
    dc = 0; res = 'x;
    for (int k = 1; k <= 16; k++) begin
      if (k == 3) begin bus.start = 1'b1; bus.bin_in = 8'd7; end
      else bus.start = 1'b0;
      tick();
      if (bus.done) begin dc++; if (dc == 1) res = bus.bcd_out; end
    end
    vectors++;
    if (dc !== 1) begin miscompares++; $display("FAIL ignore_done_count: got %0d expected 1", dc); end
    vectors++;
    if (res !== 16'h0042) begin miscompares++; $display("FAIL ignore_bcd: got %h expected 0042", res); end
    run_conv(8'd7, lat, bc, dc2, res2, n);
    vectors++;
    if (res2 !== 16'h0007) begin miscompares++; $display("FAIL fresh_after_ignore: got %h expected 0007", res2); end
  endtask

  task automatic test_reset_abort();
    int dc; int lat, bc, dc2; logic [15:0] res; logic n;
    bus.start = 1'b1; bus.bin_in = 8'd200;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0 || bus.bcd_out !== 16'h0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_state: got busy=%b bcd=%h done=%b expected 0 0000 0",
               bus.busy, bus.bcd_out, bus.done);
    end
    dc = 0;
    for (int k = 0; k < 12; k++) begin tick(); if (bus.done) dc++; end
    vectors++;
    if (dc !== 0) begin miscompares++; $display("FAIL abort_no_done: got %0d expected 0", dc); end
    run_conv(8'd200, lat, bc, dc2, res, n);
    vectors++;
    if (res !== 16'h0200) begin miscompares++; $display("FAIL after_abort: got %h expected 0200", res); end
  endtask

  task automatic test_back_to_back();
    int pos[$];
    logic [15:0] res[$];
    bus.start = 1'b1; bus.bin_in = 8'd13;
    for (int k = 0; k < 45; k++) begin
      tick();
      if (bus.done) begin pos.push_back(k); res.push_back(bus.bcd_out); end
    end
    bus.start = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    vectors++;
    if (pos.size() !== 4) begin miscompares++; $display("FAIL hold_done_count: got %0d expected 4", pos.size()); end
    for (int i = 1; i < pos.size(); i++) begin
      vectors++;
      if (pos[i] - pos[i-1] !== 10) begin
        miscompares++; $display("FAIL hold_spacing_%0d: got %0d expected 10", i, pos[i] - pos[i-1]);
      end
    end
    foreach (res[i]) begin
      vectors++;
      if (res[i] !== 16'h0013) begin miscompares++; $display("FAIL hold_bcd_%0d: got %h expected 0013", i, res[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_values();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
